// File: rtl/ctrl_pkg.sv
// Shared types and constants for the registered control decoder.
//   ctrl_state_e  : pipeline FSM states (HALT only reachable with CTRL_HALT_DETECT_EN)
//   ctrl_bundle_t : decoded control fields carried from decoder to output register
//   OP_*          : casez opcode patterns for the 9-bit instruction word
package ctrl_pkg;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, HALT} ctrl_state_e;

  // Native field widths; the top level extends/truncates to OPWIDTH and LUT_BITS.
  typedef struct packed {
    logic       load_mem;
    logic       store_mem;
    logic       reg_write;
    logic       mov_instr;
    logic [3:0] alu_op;
    logic [1:0] branch;
    logic [3:0] target_lut;
    logic       halt;
  } ctrl_bundle_t;

  localparam logic [3:0] ALUOP_MOV = 4'd8;
  localparam logic [3:0] ALUOP_NOP = 4'd9;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_JCND  = 2'b01;
  localparam logic [1:0] BR_NJCND = 2'b10;
  localparam logic [1:0] BR_JMP   = 2'b11;

  localparam logic [8:0] OP_MOV   = 9'b1????????;
  localparam logic [8:0] OP_ALU   = 9'b01???????;
  localparam logic [8:0] OP_JMP   = 9'b00100????;
  localparam logic [8:0] OP_JCND  = 9'b00101????;
  localparam logic [8:0] OP_NJCND = 9'b00110????;
  localparam logic [8:0] OP_LOAD  = 9'b00010????;
  localparam logic [8:0] OP_STORE = 9'b00011????;
  localparam logic [8:0] OP_NOP   = 9'b00111????;
  localparam logic [8:0] OP_HALT  = 9'b000000000;

  localparam ctrl_bundle_t CTRL_DEFAULT = '{
    load_mem:   1'b0,
    store_mem:  1'b0,
    reg_write:  1'b0,
    mov_instr:  1'b0,
    alu_op:     ALUOP_NOP,
    branch:     BR_NONE,
    target_lut: 4'd0,
    halt:       1'b0
  };

  function automatic logic is_mem_op(input ctrl_bundle_t b);
    return b.load_mem | b.store_mem;
  endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Purely combinational instruction decoder.
//   instr_i [8:0] : machine code
//   ctrl_o        : decoded control bundle (unlisted encodings decode as nop)
// Optional feature macro: CTRL_HALT_DETECT_EN (000000000 decodes as halt).
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [8:0]   instr_i,
  output ctrl_bundle_t ctrl_o
);

  always_comb begin
    ctrl_o = CTRL_DEFAULT;
    unique casez (instr_i)
`ifdef CTRL_HALT_DETECT_EN
      OP_HALT:  ctrl_o.halt = 1'b1;
`endif
      OP_MOV: begin
        ctrl_o.alu_op    = ALUOP_MOV;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mov_instr = 1'b1;
      end
      OP_ALU: begin
        ctrl_o.alu_op    = instr_i[7:4];
        ctrl_o.reg_write = 1'b1;
      end
      OP_JMP: begin
        ctrl_o.branch     = BR_JMP;
        ctrl_o.target_lut = instr_i[3:0];
      end
      OP_JCND: begin
        ctrl_o.branch     = BR_JCND;
        ctrl_o.target_lut = instr_i[3:0];
      end
      OP_NJCND: begin
        ctrl_o.branch     = BR_NJCND;
        ctrl_o.target_lut = instr_i[3:0];
      end
      OP_LOAD: begin
        ctrl_o.load_mem  = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OP_STORE: ctrl_o.store_mem = 1'b1;
      OP_NOP:   ctrl_o = CTRL_DEFAULT;
      default:  ctrl_o = CTRL_DEFAULT;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered, handshaked control decoder between fetch (in_*) and execute (out_*).
// Ports:
//   Clk, Reset          : clock and synchronous active-high reset
//   in_valid/in_ready   : fetch handshake, instr is the 9-bit machine code
//   branch_taken        : branch outcome, used only when a branch bundle handshakes out
//   out_valid/out_ready : execute handshake for the registered control bundle
//   loadMem..targetLUT  : registered control bundle
//   mem_busy            : FSM is in MEM_WAIT
//   halted              : sticky halt flag
// Optional feature macro: CTRL_HALT_DETECT_EN (halt instruction parks the FSM in HALT).
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned OPWIDTH     = 4,
  parameter int unsigned LUT_BITS    = 4,
  parameter int unsigned MEM_LAT     = 2,
  parameter int unsigned FLUSH_SLOTS = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8:0]          instr,
  input  logic                branch_taken,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                loadMem,
  output logic                storeMem,
  output logic                regWrite,
  output logic                movInstr,
  output logic [OPWIDTH-1:0]  ALUOp,
  output logic [1:0]          Branch,
  output logic [LUT_BITS-1:0] targetLUT,
  output logic                mem_busy,
  output logic                halted
);

  localparam int unsigned CntW = 8;

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  ctrl_bundle_t    bundle_q, bundle_d;
  ctrl_bundle_t    dec;
  logic            in_ready_c;
  logic            out_hs, drain_mem, drain_taken, drain_halt;

  ctrl_decode_comb u_decode (
    .instr_i (instr),
    .ctrl_o  (dec)
  );

  assign out_hs      = out_valid_q & out_ready;
  assign drain_mem   = out_hs & is_mem_op(bundle_q);
  assign drain_taken = out_hs & (bundle_q.branch != BR_NONE) & branch_taken & (FLUSH_SLOTS != 0);
`ifdef CTRL_HALT_DETECT_EN
  assign drain_halt  = out_hs & bundle_q.halt;
`else
  assign drain_halt  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    in_ready_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        // Fetch is held off in the cycle a load/store, taken branch or halt drains, so nothing
        // from the wrong side of the redirect/stall ever lands in the output register.
        in_ready_c = (~out_valid_q | out_ready) & ~drain_mem & ~drain_taken & ~drain_halt;
        if (out_hs) out_valid_d = 1'b0;
        if (in_valid && in_ready_c) begin
          out_valid_d = 1'b1;
          bundle_d    = dec;
        end
        if (drain_mem) begin
          state_d = MEM_WAIT;
          cnt_d   = CntW'(MEM_LAT - 1);
        end else if (drain_taken) begin
          state_d = FLUSH;
          cnt_d   = CntW'(FLUSH_SLOTS);
        end else if (drain_halt) begin
          state_d = HALT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      FLUSH: begin
        // Wrong-path slots are accepted and dropped.
        in_ready_c = 1'b1;
        if (in_valid) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = RUN;
        end
      end
`ifdef CTRL_HALT_DETECT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= CTRL_DEFAULT;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign loadMem   = bundle_q.load_mem;
  assign storeMem  = bundle_q.store_mem;
  assign regWrite  = bundle_q.reg_write;
  assign movInstr  = bundle_q.mov_instr;
  assign ALUOp     = OPWIDTH'(bundle_q.alu_op);
  assign Branch    = bundle_q.branch;
  assign targetLUT = bundle_q.target_lut[LUT_BITS-1:0];
  assign mem_busy  = (state_q == MEM_WAIT);
`ifdef CTRL_HALT_DETECT_EN
  assign halted    = (state_q == HALT);
`else
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed, scoreboard-based bench for ctrl_decode_pipe.
module tb_ctrl_decode_pipe;

  localparam int unsigned OPWIDTH     = 4;
  localparam int unsigned LUT_BITS    = 4;
  localparam int unsigned MEM_LAT     = 2;
  localparam int unsigned FLUSH_SLOTS = 1;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       rw;
    logic       mv;
    logic [3:0] alu;
    logic [1:0] br;
    logic [3:0] lut;
  } exp_t;

  logic                Clk = 1'b0;
  logic                Reset;
  logic                in_valid, in_ready;
  logic [8:0]          instr;
  logic                branch_taken;
  logic                out_valid, out_ready;
  logic                loadMem, storeMem, regWrite, movInstr;
  logic [OPWIDTH-1:0]  ALUOp;
  logic [1:0]          Branch;
  logic [LUT_BITS-1:0] targetLUT;
  logic                mem_busy, halted;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   squash_left = 0;
  int   last_wait;
  logic in_hs_seen;
  exp_t q[$];

  always #5 Clk = ~Clk;

  ctrl_decode_pipe #(
    .OPWIDTH     (OPWIDTH),
    .LUT_BITS    (LUT_BITS),
    .MEM_LAT     (MEM_LAT),
    .FLUSH_SLOTS (FLUSH_SLOTS)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .branch_taken (branch_taken),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .loadMem      (loadMem),
    .storeMem     (storeMem),
    .regWrite     (regWrite),
    .movInstr     (movInstr),
    .ALUOp        (ALUOp),
    .Branch       (Branch),
    .targetLUT    (targetLUT),
    .mem_busy     (mem_busy),
    .halted       (halted)
  );

  function automatic exp_t model(input logic [8:0] i);
    exp_t e;
    e     = '0;
    e.alu = 4'd9;
    if (i[8]) begin
      e.alu = 4'd8; e.rw = 1'b1; e.mv = 1'b1;
    end else if (i[7]) begin
      e.alu = i[7:4]; e.rw = 1'b1;
    end else begin
      case (i[7:4])
        4'b0100: begin e.br = 2'b11; e.lut = i[3:0]; end
        4'b0101: begin e.br = 2'b01; e.lut = i[3:0]; end
        4'b0110: begin e.br = 2'b10; e.lut = i[3:0]; end
        4'b0010: begin e.ld = 1'b1; e.rw = 1'b1; end
        4'b0011: e.st = 1'b1;
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score handshakes, return 1 time unit after posedge.
  task automatic tick();
    exp_t got;
    @(negedge Clk);
    in_hs_seen = 1'b0;
    if (out_valid) begin
      got = {loadMem, storeMem, regWrite, movInstr, 4'(ALUOp), Branch, 4'(targetLUT)};
      if (q.size() == 0) begin
        check("unexpected_bundle", 32'(q.size()), 32'd1);
      end else begin
        check("bundle", 32'(got), 32'(q[0]));
        if (out_ready) begin
          if (q[0].br != 2'b00 && branch_taken) squash_left = FLUSH_SLOTS;
          void'(q.pop_front());
        end
      end
    end
    if (in_valid && in_ready) begin
      in_hs_seen = 1'b1;
      if (squash_left > 0) squash_left--;
      else q.push_back(model(instr));
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [8:0] i);
    int w;
    w        = 0;
    in_valid = 1'b1;
    instr    = i;
    in_hs_seen = 1'b0;
    while (!in_hs_seen && w < 20) begin
      tick();
      w++;
    end
    check("accept", 32'(in_hs_seen), 32'd1);
    in_valid  = 1'b0;
    last_wait = w - 1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    q.delete();
    squash_left = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset        = 1'b1;
    in_valid     = 1'b0;
    instr        = '0;
    branch_taken = 1'b0;
    out_ready    = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_aluop",     32'(ALUOp),     32'd9);
    check("rst_fields",    32'({loadMem, storeMem, regWrite, movInstr, Branch, targetLUT}), 32'd0);
    check("rst_mem_busy",  32'(mem_busy),  32'd0);
    check("rst_halted",    32'(halted),    32'd0);

    // ALU then mov, back to back
    send(9'b0_1010_0011);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("alu_op_a",      32'(ALUOp),     32'hA);
    send(9'b1_0000_0101);
    check("throughput",    32'(last_wait), 32'd0);
    check("mov_flag",      32'(movInstr),  32'd1);
    tick();
    check("drained",       32'(out_valid), 32'd0);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    send(9'b0_1011_0000);
    in_valid = 1'b1;
    instr    = 9'b0_1100_0001;
    repeat (3) begin
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_stable",    32'(ALUOp),     32'hB);
      tick();
    end
    out_ready = 1'b1;
    send(9'b0_1100_0001);
    check("bp_resume", 32'(last_wait), 32'd0);
    tick();
    check("bp_q_empty", 32'(q.size()), 32'd0);

    // Load: MEM_WAIT for MEM_LAT cycles after the drain
    send(9'b000100000);
    check("ld_drain_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("ld_busy1",  32'(mem_busy), 32'd1);
    check("ld_ready1", 32'(in_ready), 32'd0);
    tick();
    check("ld_busy2",  32'(mem_busy), 32'd1);
    check("ld_ready2", 32'(in_ready), 32'd0);
    tick();
    check("ld_busy3",  32'(mem_busy), 32'd0);
    check("ld_ready3", 32'(in_ready), 32'd1);

    // Taken jcnd: next accepted slot squashed, the following one not
    branch_taken = 1'b1;
    send(9'b001010110);
    check("jcnd_lut", 32'(targetLUT), 32'd6);
    check("jcnd_br",  32'(Branch),    32'b01);
    send(9'b0_1111_0000);
    check("flush_no_bundle", 32'(out_valid), 32'd0);
    send(9'b0_1110_0010);
    check("post_flush_valid", 32'(out_valid), 32'd1);
    // branch_taken still high on a non-branch drain: must be ignored
    send(9'b0_1101_0011);
    tick();
    check("taken_q_empty", 32'(q.size()), 32'd0);
    branch_taken = 1'b0;

    // Not-taken !jcnd then store-free ALU
    send(9'b001100101);
    check("njcnd_br", 32'(Branch), 32'b10);
    send(9'b0_1001_0001);
    tick();
    check("nt_q_empty", 32'(q.size()), 32'd0);

    // Reset in FLUSH
    branch_taken = 1'b1;
    send(9'b001000011);
    tick();
    check("in_flush_ready", 32'(in_ready),  32'd1);
    check("in_flush_valid", 32'(out_valid), 32'd0);
    branch_taken = 1'b0;
    do_reset();
    check("rf_out_valid", 32'(out_valid), 32'd0);
    check("rf_in_ready",  32'(in_ready),  32'd1);
    send(9'b0_1000_0111);
    tick();
    check("rf_q_empty", 32'(q.size()), 32'd0);

    // Reset in MEM_WAIT
    send(9'b000110000);
    tick();
    check("st_busy", 32'(mem_busy), 32'd1);
    do_reset();
    check("rm_mem_busy",  32'(mem_busy),  32'd0);
    check("rm_in_ready",  32'(in_ready),  32'd1);
    check("rm_out_valid", 32'(out_valid), 32'd0);

    // Reset drops a pending bundle
    out_ready = 1'b0;
    send(9'b0_1111_1111);
    check("pend_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    check("pend_dropped", 32'(out_valid), 32'd0);
    check("pend_aluop",   32'(ALUOp),     32'd9);

`ifdef CTRL_HALT_DETECT_EN
    send(9'b000000000);
    check("halt_drain_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b1;
    instr    = 9'b0_1010_0000;
    repeat (3) begin
      check("halted",        32'(halted),   32'd1);
      check("halt_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    check("halt_cleared",  32'(halted),   32'd0);
    check("halt_rst_rdy",  32'(in_ready), 32'd1);
`else
    send(9'b000000000);
    check("zero_nop_alu", 32'(ALUOp), 32'd9);
    tick();
    check("zero_not_halted", 32'(halted),   32'd0);
    check("zero_in_ready",   32'(in_ready), 32'd1);
    check("zero_q_empty",    32'(q.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
